// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: drives PC updates and memory reads,
// and hands fetched words to decode over a valid/ready pair.
module fetch_seq #(
  parameter int size = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            halt,
  input  logic [size-1:0] pcIn,
  output logic            pcWr,
  output logic [size-1:0] pcNext,
  output logic            memReq,
  output logic [size-1:0] memAddr,
  input  logic            memAck,
  input  logic [size-1:0] memData,
  input  logic            brTaken,
  input  logic [size-1:0] brTarget,
  output logic [size-1:0] instr,
  output logic            instrValid,
  input  logic            instrReady
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    UPD,
    HOLD,
    FLUSH,
    HALT
  } state_t;

  state_t          state;
  state_t          stateNx;
  logic [size-1:0] nextPc;
  logic [size-1:0] nextPcNx;
  logic [size-1:0] instrNx;
  logic            validNx;
  logic            xfer;

  assign xfer = instrValid & instrReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      nextPc     <= '0;
      instr      <= '0;
      instrValid <= 1'b0;
    end else begin
      state      <= stateNx;
      nextPc     <= nextPcNx;
      instr      <= instrNx;
      instrValid <= validNx;
    end
  end

  always_comb begin
    stateNx  = state;
    nextPcNx = nextPc;
    instrNx  = instr;
    validNx  = instrValid & ~xfer;
    unique case (state)
      IDLE: begin
        if (en) stateNx = REQ;
      end
      REQ: begin
        if (brTaken) begin
          nextPcNx = brTarget;
          validNx  = 1'b0;
          stateNx  = memAck ? UPD : FLUSH;
        end else if (memAck) begin
          instrNx  = memData;
          validNx  = 1'b1;
          nextPcNx = pcIn + size'(2);
          stateNx  = UPD;
        end
      end
      UPD: begin
        if (halt) begin
          stateNx = HALT;
        end else if (brTaken) begin
          // re-enter UPD so the redirect gets its own PC write
          nextPcNx = brTarget;
          validNx  = 1'b0;
          stateNx  = UPD;
        end else if (instrValid && !instrReady) begin
          stateNx = HOLD;
        end else begin
          stateNx = REQ;
        end
      end
      HOLD: begin
        if (brTaken) begin
          nextPcNx = brTarget;
          validNx  = 1'b0;
          stateNx  = UPD;
        end else if (xfer) begin
          stateNx = REQ;
        end
      end
      FLUSH: begin
        if (brTaken) nextPcNx = brTarget;
        if (memAck) stateNx = UPD;
      end
      HALT: begin
        stateNx = HALT;
      end
      default: begin
        stateNx = IDLE;
      end
    endcase
  end

  // strobes decode straight from state so reset clears them at once
  assign pcWr    = (state == UPD);
  assign pcNext  = nextPc;
  assign memReq  = (state == REQ) || (state == FLUSH);
  assign memAddr = memReq ? pcIn : '0;

endmodule
